// File: rtl/pomodoro_pkg.sv
// Shared types and helpers for the Pomodoro countdown core.
package pomodoro_pkg;

  localparam int BCD_W  = 4;
  localparam int TIME_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // True when every digit of an MMSS value is decimal and the seconds tens digit is 0..5.
  function automatic logic bcdTimeValid(input logic [TIME_W-1:0] t);
    return (t[15:12] <= 4'd9) && (t[11:8] <= 4'd9) &&
           (t[7:4]   <= 4'd5) && (t[3:0]  <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_mmss_down.sv
// Four-digit MMSS BCD down-counter with synchronous load and a zero look-ahead flag.
module bcd_mmss_down
  import pomodoro_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [TIME_W-1:0] load_val,
  input  logic              dec,
  output logic [TIME_W-1:0] value,
  output logic              zero_next
);

  logic [TIME_W-1:0] value_q;
  logic [TIME_W-1:0] decVal;

  // Ripple a one-second borrow through the digits: seconds wrap 0->9 and 0->5, minutes ones 0->9.
  always_comb begin
    decVal = value_q;
    if (value_q[BCD_W-1:0] != 4'd0) begin
      decVal[3:0] = value_q[3:0] - 4'd1;
    end else begin
      decVal[3:0] = 4'd9;
      if (value_q[7:4] != 4'd0) begin
        decVal[7:4] = value_q[7:4] - 4'd1;
      end else begin
        decVal[7:4] = 4'd5;
        if (value_q[11:8] != 4'd0) begin
          decVal[11:8] = value_q[11:8] - 4'd1;
        end else begin
          decVal[11:8]  = 4'd9;
          decVal[15:12] = value_q[15:12] - 4'd1;
        end
      end
    end
  end

  // Load has priority over a decrement, and the count never moves below 00:00.
  always_ff @(posedge clk) begin
    if (!rst) begin
      value_q <= '0;
    end else if (load) begin
      value_q <= load_val;
    end else if (dec && (value_q != '0)) begin
      value_q <= decVal;
    end
  end

  assign value     = value_q;
  assign zero_next = dec && (value_q == 16'h0001);

endmodule

// File: rtl/pomodoro_countdown_core.sv
// Pomodoro countdown core: button edge detect, preset mux, one-second prescaler and run/pause FSM.
module pomodoro_countdown_core
  import pomodoro_pkg::*;
#(
  parameter int                           TICK_DIV   = 125_000_000,
  parameter int                           NUM_PRESET = 4,
  parameter logic [TIME_W*NUM_PRESET-1:0] PRESET_BCD = {16'h5000, 16'h2500, 16'h1000, 16'h0500}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_PRESET-1:0] btn,
  input  logic                  pause_btn,
  output logic [TIME_W-1:0]     remain_bcd,
  output logic [TIME_W-1:0]     set_bcd,
  output logic                  running,
  output logic                  paused,
  output logic                  done
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  if (TICK_DIV < 2) begin : gBadTickDiv
    $error("pomodoro_countdown_core: TICK_DIV must be at least 2");
  end
  if ((NUM_PRESET < 1) || (NUM_PRESET > 8)) begin : gBadNumPreset
    $error("pomodoro_countdown_core: NUM_PRESET must be 1..8");
  end
  for (genvar gi = 0; gi < NUM_PRESET; gi++) begin : gPresetCheck
    if (!bcdTimeValid(PRESET_BCD[TIME_W*gi +: TIME_W])) begin : gBadPreset
      $error("pomodoro_countdown_core: preset %0d is not a valid MMSS BCD time", gi);
    end
  end

  state_e                state_q, state_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [NUM_PRESET-1:0] btnPrev_q;
  logic                  pausePrev_q;
  logic [TIME_W-1:0]     setVal_q, setVal_d;
  logic                  running_q, running_d;
  logic                  paused_q, paused_d;
  logic                  done_q, done_d;

  logic [NUM_PRESET-1:0] btnRise;
  logic                  pauseRise;
  logic [TIME_W-1:0]     selVal;
  logic                  anyRise;
  logic                  presetHit;
  logic                  tickWrap;
  logic                  decReq;
  logic                  zeroNext;
  logic [TIME_W-1:0]     remainVal;

  assign btnRise   = btn & ~btnPrev_q;
  assign pauseRise = pause_btn & ~pausePrev_q;
  assign tickWrap  = (presc_q == PRESC_MAX);

  // Pick the lowest-indexed rising preset button; an all-zero preset counts as no press at all.
  always_comb begin
    selVal  = '0;
    anyRise = 1'b0;
    for (int i = NUM_PRESET - 1; i >= 0; i--) begin
      if (btnRise[i]) begin
        selVal  = PRESET_BCD[TIME_W*i +: TIME_W];
        anyRise = 1'b1;
      end
    end
    presetHit = anyRise && (selVal != '0);
  end

  assign decReq = !presetHit && (state_q == RUN) && !pauseRise && tickWrap;

  bcd_mmss_down u_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (presetHit),
    .load_val  (selVal),
    .dec       (decReq),
    .value     (remainVal),
    .zero_next (zeroNext)
  );

  // Next state: a preset press overrides everything; a pause cycle still counts as run time unless it lands on the tick.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    setVal_d = setVal_q;
    if (presetHit) begin
      setVal_d = selVal;
      presc_d  = '0;
      state_d  = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (pauseRise) begin
            state_d = PAUSE;
            if (!tickWrap) begin
              presc_d = presc_q + PW'(1);
            end
          end else if (tickWrap) begin
            presc_d = '0;
            if (zeroNext) begin
              state_d = DONE;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        PAUSE: begin
          if (pauseRise) begin
            state_d = RUN;
          end
        end
        default: begin
        end
      endcase
    end
    running_d = (state_d == RUN);
    paused_d  = (state_d == PAUSE);
    done_d    = decReq && zeroNext;
  end

  // State, prescaler, edge-detect history and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      btnPrev_q   <= '0;
      pausePrev_q <= 1'b0;
      setVal_q    <= '0;
      running_q   <= 1'b0;
      paused_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      btnPrev_q   <= btn;
      pausePrev_q <= pause_btn;
      setVal_q    <= setVal_d;
      running_q   <= running_d;
      paused_q    <= paused_d;
      done_q      <= done_d;
    end
  end

  assign remain_bcd = remainVal;
  assign set_bcd    = setVal_q;
  assign running    = running_q;
  assign paused     = paused_q;
  assign done       = done_q;

endmodule
